// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide op encoding and the md_unit FSM state type.
package mips_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_divider.sv
// One restoring-divide step: shift the next dividend bit into the partial remainder,
// subtract the divisor when it fits, and shift the resulting quotient bit in.
module md_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // The remainder is always below the divisor, so the difference fits in WIDTH bits.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs});
    rem_nxt = fits ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one result bit per RUN cycle.
// Divide support (md_divider) is built only when MD_UNIT_DIV_EN is defined.
module md_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic sgn);
    return (sgn && (v < 0)) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] fix_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? WIDTH'(-$signed(v)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (2*WIDTH)'(-$signed(v)) : v;
  endfunction

  md_state_t        state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             accept, ld, step, finish, sgn_op, neg_q;
  logic [WIDTH-1:0] mcand, ph, pl, ph_nxt, pl_nxt;
  logic [WIDTH:0]   sum;

  assign sgn_op = (op == MD_MULT) || (op == MD_DIV);

`ifdef MD_UNIT_DIV_EN
  logic             div_q, dz_q, aneg_q;
  logic [WIDTH-1:0] a_q, rem, quo, dvs, rem_nxt, quo_nxt;

  assign accept = start;

  md_divider #(.WIDTH(WIDTH)) u_div (
    .rem     (rem),
    .quo     (quo),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );
`else
  assign accept = start && ((op == MD_MULT) || (op == MD_MULTU));
`endif

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    ld        = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      MD_IDLE: begin
        if (!flush && accept) begin
          state_nxt = MD_RUN;
          stall     = 1'b1;
          ld        = 1'b1;
        end
      end
      MD_RUN: begin
        if (flush) begin
          state_nxt = MD_IDLE;
        end else begin
          stall = 1'b1;
          step  = 1'b1;
          if (cnt == '0) begin
            state_nxt = MD_DONE;
            finish    = 1'b1;
          end
        end
      end
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (flush)
        cnt <= '0;
      else if (ld)
        cnt <= CNT_TOP;
      else if (step && (cnt != '0))
        cnt <= cnt - 1'b1;
    end
  end

  // Shift-add step: add the multiplicand into the high half, then shift the pair right.
  always_comb begin
    sum    = {1'b0, ph} + (pl[0] ? {1'b0, mcand} : '0);
    ph_nxt = sum[WIDTH:1];
    pl_nxt = {sum[0], pl[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (ld) begin
      mcand  <= mag(a, sgn_op);
      ph     <= '0;
      pl     <= mag(b, sgn_op);
      neg_q  <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MD_UNIT_DIV_EN
      div_q  <= (op == MD_DIV) || (op == MD_DIVU);
      dz_q   <= (b == '0);
      aneg_q <= sgn_op && a[WIDTH-1];
      a_q    <= a;
      rem    <= '0;
      quo    <= mag(a, sgn_op);
      dvs    <= mag(b, sgn_op);
`endif
    end else if (step) begin
      ph     <= ph_nxt;
      pl     <= pl_nxt;
`ifdef MD_UNIT_DIV_EN
      rem    <= rem_nxt;
      quo    <= quo_nxt;
`endif
    end
  end

  // HI/LO take the sign-corrected result on the edge ending the last RUN cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (finish) begin
`ifdef MD_UNIT_DIV_EN
      if (div_q) begin
        if (dz_q) begin
          hi <= a_q;
          lo <= '1;
        end else begin
          hi <= fix_w(rem_nxt, aneg_q);
          lo <= fix_w(quo_nxt, neg_q);
        end
      end else begin
        {hi, lo} <= fix_2w({ph_nxt, pl_nxt}, neg_q);
      end
`else
      {hi, lo} <= fix_2w({ph_nxt, pl_nxt}, neg_q);
`endif
    end else if ((state == MD_IDLE) && !flush && !accept) begin
      if (mthi) hi <= a;
      if (mtlo) lo <= a;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: spec vector table, hand-written flush/reset/MTHI
// sequences and randomized operations against a plain-arithmetic reference model.
module tb_md_unit;

  localparam int W = 32;
`ifdef MD_UNIT_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          mthi = 1'b0;
  logic          mtlo = 1'b0;
  logic          stall;
  logic [W-1:0]  hi, lo;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] cur_hi = '0, cur_lo = '0;

  md_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .start(start), .op(op),
    .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Reference model: results straight from the architectural definition of each op.
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] mh, output logic [W-1:0] ml);
    longint          sp;
    logic [63:0]     up;
    int              sx, sy;
    mh = cur_hi;
    ml = cur_lo;
    case (o)
      2'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {mh, ml} = sp;
      end
      2'd1: begin
        up = {32'd0, x} * {32'd0, y};
        {mh, ml} = up;
      end
      2'd2: if (DIV_EN) begin
        sx = x; sy = y;
        if (y == 0) begin
          ml = 32'hFFFF_FFFF; mh = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          ml = 32'h8000_0000; mh = 32'd0;
        end else begin
          ml = sx / sy; mh = sx % sy;
        end
      end
      default: if (DIV_EN) begin
        if (y == 0) begin
          ml = 32'hFFFF_FFFF; mh = x;
        end else begin
          ml = x / y; mh = x % y;
        end
      end
    endcase
  endtask

  // Issue one command and count the cycles stall stays high; returns during the DONE cycle.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int ncyc);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    ncyc = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (!stall) break;
      ncyc++;
      @(negedge clk);
      start = 1'b0;
      a = $urandom;
      b = $urandom;
    end
    if (ncyc == 0) begin
      @(negedge clk);
      start = 1'b0;
      #1;
    end
    start = 1'b0;
  endtask

  function automatic int exp_cycles(input logic [1:0] o);
    return (o[1] && !DIV_EN) ? 0 : W + 1;
  endfunction

  vec_t vecs[10];

  initial begin
    int           n;
    logic [W-1:0] eh, el;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    vecs[0] = '{2'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{2'd1, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{2'd2, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'd3, 32'd100,        32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4] = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'd2, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6] = '{2'd0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7] = '{2'd3, 32'hFFFF_FFFF,  32'd16,        32'h0000_000F, 32'h0FFF_FFFF};
    vecs[8] = '{2'd2, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9] = '{2'd0, 32'd0,          32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};

    // Reset state
    #12;
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      eh = (vecs[i].op[1] && !DIV_EN) ? cur_hi : vecs[i].exp_hi;
      el = (vecs[i].op[1] && !DIV_EN) ? cur_lo : vecs[i].exp_lo;
      chk($sformatf("vec%0d_cycles", i), n, exp_cycles(vecs[i].op));
      chk($sformatf("vec%0d_hi", i), hi, eh);
      chk($sformatf("vec%0d_lo", i), lo, el);
      cur_hi = eh; cur_lo = el;
    end

    // MTHI / MTLO, one-cycle latency
    @(negedge clk);
    mthi = 1'b1; a = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; a = 32'hCAFE_F00D;
    #1;
    chk("mthi_hi", hi, 32'h1234_5678);
    @(negedge clk);
    mtlo = 1'b0;
    #1;
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);

    // MULT 3x4 flushed in RUN cycle 10
    @(negedge clk);
    op = 2'd0; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("flush_pre_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_same_cycle_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_next_stall", {31'd0, stall}, 32'd0);
    repeat (30) @(negedge clk);
    #1;
    chk("flush_hi_kept", hi, 32'h1234_5678);
    chk("flush_lo_kept", lo, 32'hCAFE_F00D);

    // Flush beats start while idle
    @(negedge clk);
    op = 2'd1; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
    #1;
    chk("flush_start_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_start_idle", {31'd0, stall}, 32'd0);
    chk("flush_start_lo", lo, 32'hCAFE_F00D);

    // Reset during RUN cycle 5, then a fresh MULTU 5x5
    @(negedge clk);
    op = 2'd1; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_hi", hi, '0);
    chk("midreset_lo", lo, '0);
    chk("midreset_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("postreset_stall", {31'd0, stall}, 32'd0);
    cur_hi = '0; cur_lo = '0;
    run_op(2'd1, 32'd5, 32'd5, n);
    chk("multu55_cycles", n, W + 1);
    chk("multu55_lo", lo, 32'd25);
    chk("multu55_hi", hi, 32'd0);
    cur_lo = 32'd25;

    // Randomized back-to-back operations
    for (int k = 0; k < 40; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = ~rb + 1'b1 | 32'h8000_0000;
        default: ;
      endcase
      model(ro, ra, rb, eh, el);
      run_op(ro, ra, rb, n);
      chk($sformatf("rnd%0d_cycles op%0d", k, ro), n, exp_cycles(ro));
      chk($sformatf("rnd%0d_hi op%0d a%h b%h", k, ro, ra, rb), hi, eh);
      chk($sformatf("rnd%0d_lo op%0d a%h b%h", k, ro, ra, rb), lo, el);
      cur_hi = eh; cur_lo = el;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit sitting in the EX stage of the MIPS pipeline, alongside the ALU. It executes MULT/MULTU/DIV/DIVU over multiple cycles and owns the architectural HI/LO registers. Its `stall` output drives, through the hazard unit, the `en` inputs of the IF/ID and ID/EX pipeline registers, freezing the front of the pipeline while an operation is in flight. It also services MTHI/MTLO writes and provides HI/LO for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand width and width of HI and LO.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low.
- `flush` in 1: synchronous clear; aborts any operation in flight.
- `start` in 1: EX-stage instruction is a multiply/divide op.
- `op` in 2: operation select; 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `a` in WIDTH: rs operand; multiplicand or dividend.
- `b` in WIDTH: rt operand; multiplier or divisor.
- `mthi` in 1: write `a` into HI.
- `mtlo` in 1: write `a` into LO.
- `stall` out 1: hold upstream pipeline registers.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- FSM with three states.
  - IDLE: accepts commands.
  - RUN: iterating; a counter runs from WIDTH-1 down to 0.
  - DONE: one cycle; `start` is ignored, which lets the held instruction leave EX.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE when the counter reaches 0.
  - DONE→IDLE unconditionally.
- Priority, highest first: `reset`, then `flush`, then `start`, then `mthi`/`mtlo`.
- Operands are latched on IDLE→RUN. Later changes on `a`/`b` have no effect.
- Signed ops (MULT, DIV) operate on magnitudes. The sign is fixed at completion:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Multiply uses shift-add, one bit per RUN cycle. The 2·WIDTH-bit product goes {HI, LO}.
- Divide is restoring, one quotient bit per RUN cycle. LO gets the quotient; HI gets the remainder.
- Divide by zero: LO = all ones, HI = dividend (for DIV this is the dividend after sign fix-up). No trap.
- Signed most-negative ÷ −1: LO = most-negative value, HI = 0.
- `mthi`/`mtlo` take effect only in IDLE. They are ignored in RUN and DONE; the hazard unit never issues them there.
- `flush`: state→IDLE, counter cleared, HI/LO keep their previous values.
- Reset: state IDLE, counter 0, `hi` = 0, `lo` = 0, `stall` = 0.
- Reset asserted mid-operation: immediate return to the reset values; the partial result is discarded.

## Timing
- `stall` is combinational: high when state=RUN, or when state=IDLE and `start` is high and `flush` is low.
- Command presented in cycle 0 (IDLE, `stall` high).
- Cycles 1..WIDTH: RUN, `stall` high.
- Cycle WIDTH+1: DONE, `stall` low, `hi`/`lo` already hold the result.
- Net effect: `stall` is high for exactly WIDTH+1 consecutive cycles per operation.
- HI/LO update on the clock edge ending the last RUN cycle.
- A new `start` in the cycle after DONE is accepted back-to-back.
- `mthi`/`mtlo` latency: 1 cycle; the value is visible on `hi`/`lo` the next cycle.
- `flush` in any RUN cycle: `stall` is low in that same cycle and the state is IDLE the next cycle.

## Configuration
- `MD_UNIT_DIV_EN` defined: all four ops are supported as above.
- `MD_UNIT_DIV_EN` undefined: the divider datapath is not built. DIV/DIVU are treated as no-ops:
  - `stall` is never asserted for them.
  - HI/LO are unchanged.
  - The FSM stays in IDLE.
- MULT/MULTU behave identically in both configurations.

## Structure
- The shared package `mips_pkg` holds:
  - the `op` encoding constants (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - the FSM state typedef (MD_IDLE, MD_RUN, MD_DONE).
- One sub-module: `md_divider`, the restoring-divide step datapath.
  - Instantiated only under `MD_UNIT_DIV_EN`.
  - The shift-add multiplier, counter, sign fix-up and FSM stay in `md_unit`.

## Test plan
All scenarios use WIDTH=32.
- MULT a=7, b=0xFFFFFFFD (−3) → `stall` high 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=0x00000064.
- MTHI a=0x12345678 → hi=0x12345678 next cycle. Then MULT 3×4, with `flush` pulsed in RUN cycle 10 → `stall` low in that cycle; hi/lo remain 0x12345678 / prior value.
- Start MULTU 5×5 and assert `reset` low in RUN cycle 5 → hi=lo=0 and `stall`=0 immediately. After release, a new MULTU 5×5 completes with lo=25.
